// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one word per frame from a synchronous FIFO and
// serialises it as start bit, DW data bits LSB first, one stop bit.
module fifo_uart_tx #(
  parameter int DW           = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          fifo_empty,
  output logic          fifo_re,
  input  logic [DW-1:0] fifo_rdata,
  output logic          txd,
  output logic          busy,
  output logic          frame_done
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(DW) + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DW - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    LATCH,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state, state_next;
  logic [BW-1:0] baud_cnt, baud_next;
  logic [CW-1:0] bit_cnt, bit_next;
  logic [DW-1:0] shift_reg, shift_next;
  logic          baud_end;

  assign baud_end = (baud_cnt == BAUD_LAST);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create order-dependent
  // simulation races against the combinational next-state logic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      // NOTE: the shift register is a handful of flops, not a RAM, so it is
      // reset with the rest of the state at no real cost.
      shift_reg <= '0;
    end else begin
      state     <= state_next;
      baud_cnt  <= baud_next;
      bit_cnt   <= bit_next;
      shift_reg <= shift_next;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before the case, so branches that
    // leave a signal untouched hold it in the register rather than a latch.
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_cnt;
    shift_next = shift_reg;

    unique case (state)
      IDLE: begin
        // Sole reader of the FIFO: a non-empty flag seen here cannot vanish before REQ.
        if (enable && !fifo_empty) state_next = REQ;
      end
      REQ: begin
        state_next = LATCH;
      end
      LATCH: begin
        shift_next = fifo_rdata;
        baud_next  = '0;
        bit_next   = '0;
        state_next = START;
      end
      START: begin
        if (baud_end) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = DATA;
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_next  = '0;
          shift_next = shift_reg >> 1;
          bit_next   = bit_cnt + 1'b1;
          if (bit_cnt == BIT_LAST) state_next = STOP;
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_next  = '0;
          state_next = IDLE;
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs decode registers only, so reset forces them without a clock edge.
  always_comb begin
    fifo_re    = (state == REQ);
    busy       = (state != IDLE);
    frame_done = (state == STOP) && baud_end;
    txd        = 1'b1;
    if (state == START) txd = 1'b0;
    else if (state == DATA) txd = shift_reg[0];
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Downstream drain stage for the synchronous FIFO: pops one word at a time through the FIFO read port (`re`/`rdata`/`empty`) and transmits it on a serial line as an asynchronous 8N1-style frame: start bit, DW data bits LSB first, one stop bit. It turns buffered parallel data into a UART TX stream. It is the only reader of the FIFO it drains.

## Interface
Parameters:
- DW, 8: data word width; must equal the FIFO data width.
- CLKS_PER_BIT, 16: clk cycles per serial bit; legal range >= 2.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  permits starting a new frame; sampled only in IDLE.
- fifo_empty  input  1  FIFO empty flag.
- fifo_re  output  1  FIFO read strobe, high exactly one cycle per frame.
- fifo_rdata  input  DW  FIFO read data; valid the cycle after fifo_re is high.
- txd  output  1  serial output, idle high.
- busy  output  1  high in every state except IDLE.
- frame_done  output  1  one-cycle pulse in the final cycle of the stop bit.

## Operation
- One clock. Reset is asynchronous and active-high.
- State machine: IDLE, REQ, LATCH, START, DATA, STOP. The state, shift register, baud counter and bit counter are all registers.
- IDLE: txd=1, busy=0. If enable && !fifo_empty, go to REQ. Otherwise stay in IDLE.
- REQ: fifo_re=1, decoded from the state register with no combinational path from inputs. Always go to LATCH.
- LATCH: capture fifo_rdata into the DW-bit shift register. Clear the baud counter. Go to START.
- START: txd=0 for CLKS_PER_BIT cycles, then go to DATA with bit counter = 0.
- DATA: txd = shift_reg[0]. Each bit lasts CLKS_PER_BIT cycles. At the end of each bit, shift right and increment the bit counter. After bit DW-1, go to STOP.
- STOP: txd=1 for CLKS_PER_BIT cycles. frame_done=1 in the last of those cycles. Then go to IDLE.
- Baud counter: width $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
- Bit counter: width $clog2(DW)+1.
- No valid-FIFO-data condition can disappear between IDLE and REQ, because this block is the sole reader. fifo_empty is therefore checked only in IDLE.
- enable deasserted mid-frame: the current frame completes unchanged, and no new frame starts.
- fifo_rdata is ignored in every state except LATCH.

## Timing
- Reset values: txd=1, fifo_re=0, busy=0, frame_done=0, state=IDLE, counters=0, shift register=0.
- Reset asserted mid-frame forces the reset values immediately, without waiting for a clock. The frame is abandoned. The word already popped is lost; this is accepted behaviour.
- Let cycle 0 be the REQ cycle. Then:
  - cycle 1: LATCH.
  - cycles 2 .. CLKS_PER_BIT+1: start bit.
  - data bit i: cycles 2+(i+1)*CLKS_PER_BIT .. 2+(i+2)*CLKS_PER_BIT-1.
  - stop bit: cycles 2+(DW+1)*CLKS_PER_BIT .. (DW+2)*CLKS_PER_BIT+1.
  - frame_done is high in cycle (DW+2)*CLKS_PER_BIT+1.
- Back-to-back frames (FIFO non-empty, enable=1): one IDLE cycle, then REQ. Frame start-to-start spacing is (DW+2)*CLKS_PER_BIT+3 cycles.
- Latency: the first low txd cycle occurs 2 cycles after fifo_re, and 3 cycles after IDLE sees the start condition.
- busy rises in the REQ cycle. busy falls on entry to IDLE, one cycle after frame_done.

## Test plan
- Reset with FIFO empty, enable=1 for 100 cycles -> txd=1, fifo_re=0, busy=0 throughout.
- DW=8, CLKS_PER_BIT=4, one word 0xA5 in the FIFO -> fifo_re pulses once. txd holds each level for 4 cycles in this order: start bit 0, then data bits 1,0,1,0,0,1,0,1 (LSB first), then stop bit 1. frame_done fires once at cycle 41 relative to REQ. busy returns to 0.
- FIFO preloaded with 0x00, 0xFF, 0x3C, enable=1 -> three frames decode correctly with REQ cycles spaced 43 cycles apart. fifo_re pulses exactly 3 times. The FIFO ends empty.
- enable dropped during the DATA state of frame 1 while 2 words are still queued -> frame 1 completes intact, no further fifo_re occurs, and the remaining words are still in the FIFO.
- reset pulsed during the DATA state -> txd=1 and busy=0 without waiting for a clock edge. After release, with the FIFO non-empty, a fresh frame starts with the next FIFO word.
- CLKS_PER_BIT=2 boundary -> each bit lasts exactly 2 cycles and the frame length is 20 cycles from the start-bit edge to the end of the stop bit.
